// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: ws channel encoding, default FIFO size
// and the per-bit serialiser rule shared by the datapath.
package i2s_pkg;

    localparam int unsigned FIFO_AW_DEFAULT = 5;
    localparam int unsigned SAMPLE_W        = 32;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } ws_chan_e;

    // Serial bit k of a slot carrying sample s of n bits; Philips mode delays by one sck.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input logic [4:0] n,
                                      input logic [4:0] k, input logic lj);
        logic b;
        b = 1'b0;
        if (lj) begin
            if (k < n) b = s[n - k - 5'd1];
        end else if ((k != 5'd0) && (k <= n)) begin
            b = s[n - k];
        end
        return b;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Transmit sample FIFO: registered pointers and flags, combinational read data.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned AW = FIFO_AW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                rd,
    output logic [SAMPLE_W-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic [AW:0]         level
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         level_q;
    logic [AW:0]         level_d;
    logic                full_q;
    logic                empty_q;
    logic                push_c;
    logic                pop_c;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_c  = wr && !full_q;
    assign pop_c   = rd && !empty_q;
    assign level_d = level_q + LW'(push_c) - LW'(pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified serial transmitter fed from a sample FIFO.
// Define I2S_TX_UNDERFLOW_HOLD_EN to repeat the channel's last sample on underflow.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_AW = FIFO_AW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                sck,
    output logic                ws,
    output logic                sdo,
    input  logic                fifo_wr,
    input  logic [SAMPLE_W-1:0] fifo_wdata,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic [FIFO_AW:0]    fifo_level,
    input  logic [FIFO_AW:0]    fifo_level_threshold,
    output logic                fifo_level_below,
    input  logic                left_justified,
    input  logic [4:0]          sample_size,
    input  logic [7:0]          sck_prescaler,
    input  logic [1:0]          channels,
    input  logic                en,
    output logic                underflow
);

    logic [7:0]          presc_q, presc_d;
    logic                sck_q, sck_d;
    ws_chan_e            ws_q, ws_d;
    logic [4:0]          k_q, k_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sdo_q, sdo_d;
    logic                underflow_q, underflow_d;
    logic                fall_c;
    logic                pop_c;
    logic                chan_en_c;
    logic [SAMPLE_W-1:0] fifo_rdata;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    logic [SAMPLE_W-1:0] hold_left_q, hold_left_d;
    logic [SAMPLE_W-1:0] hold_right_q, hold_right_d;
`endif

    i2s_tx_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .wr   (fifo_wr),
        .wdata(fifo_wdata),
        .rd   (pop_c),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= 8'd0;
            sck_q        <= 1'b0;
            ws_q         <= RIGHT;
            k_q          <= 5'd31;
            sample_q     <= '0;
            sdo_q        <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
            hold_left_q  <= '0;
            hold_right_q <= '0;
`endif
        end else begin
            presc_q      <= presc_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            k_q          <= k_d;
            sample_q     <= sample_d;
            sdo_q        <= sdo_d;
            underflow_q  <= underflow_d;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
`endif
        end
    end

    // Everything except the prescaler advances only on sck falling events.
    always_comb begin
        presc_d      = presc_q;
        sck_d        = sck_q;
        ws_d         = ws_q;
        k_d          = k_q;
        sample_d     = sample_q;
        sdo_d        = sdo_q;
        underflow_d  = 1'b0;
        fall_c       = 1'b0;
        pop_c        = 1'b0;
        chan_en_c    = 1'b0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
`endif
        if (en) begin
            if (presc_q == 8'd0) begin
                presc_d = sck_prescaler;
                sck_d   = ~sck_q;
                fall_c  = sck_q;
            end else begin
                presc_d = presc_q - 8'd1;
            end
        end

        if (fall_c) begin
            k_d = k_q + 5'd1;
            if (k_q == 5'd31) begin
                ws_d      = (ws_q == LEFT) ? RIGHT : LEFT;
                chan_en_c = (ws_d == LEFT) ? channels[1] : channels[0];
                if (!chan_en_c) begin
                    sample_d = '0;
                end else if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    sample_d = fifo_rdata;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
                    if (ws_d == LEFT) hold_left_d = fifo_rdata;
                    else              hold_right_d = fifo_rdata;
`endif
                end else begin
                    underflow_d = 1'b1;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
                    sample_d = (ws_d == LEFT) ? hold_left_q : hold_right_q;
`else
                    sample_d = '0;
`endif
                end
            end
            sdo_d = slot_bit(sample_d, sample_size, k_d, left_justified);
        end
    end

    assign sck              = sck_q;
    assign ws               = ws_q;
    assign sdo              = sdo_q;
    assign underflow        = underflow_q;
    assign fifo_level_below = (fifo_level < fifo_level_threshold);

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a slot-level model predicts each 32-bit slot from
// the pushed samples, channel enables and serial format.
module tb_i2s_tx;

    logic        clk;
    logic        rst_n;
    logic        sck, ws, sdo;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        fifo_full, fifo_empty;
    logic [5:0]  fifo_level;
    logic [5:0]  fifo_level_threshold;
    logic        fifo_level_below;
    logic        left_justified;
    logic [4:0]  sample_size;
    logic [7:0]  sck_prescaler;
    logic [1:0]  channels;
    logic        en;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    logic [1:0]  fall_q[$];
    int          uf_cnt;
    int          uf_long;
    logic        prev_sck;
    logic        prev_uf;
    logic [31:0] mq[$];
    logic [31:0] hold_l, hold_r;
    int          slot_idx;

    i2s_tx #(.FIFO_AW(5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sck                 (sck),
        .ws                  (ws),
        .sdo                 (sdo),
        .fifo_wr             (fifo_wr),
        .fifo_wdata          (fifo_wdata),
        .fifo_full           (fifo_full),
        .fifo_empty          (fifo_empty),
        .fifo_level          (fifo_level),
        .fifo_level_threshold(fifo_level_threshold),
        .fifo_level_below    (fifo_level_below),
        .left_justified      (left_justified),
        .sample_size         (sample_size),
        .sck_prescaler       (sck_prescaler),
        .channels            (channels),
        .en                  (en),
        .underflow           (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record (ws, sdo) after every sck falling edge and underflow pulse widths.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_sck = 1'b0;
            prev_uf  = 1'b0;
        end else begin
            if (prev_sck && !sck) fall_q.push_back({ws, sdo});
            if (underflow) begin
                uf_cnt++;
                if (prev_uf) uf_long++;
            end
            prev_sck = sck;
            prev_uf  = underflow;
        end
    end

    function automatic logic [31:0] slot_word(input logic [31:0] s, input int n, input bit lj);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (lj) begin
                if (k < n) w[31-k] = s[n-1-k];
            end else if (k >= 1 && k <= n) begin
                w[31-k] = s[n-k];
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] obs_slot(input int i);
        logic [31:0] w;
        w = 'x;
        if (fall_q.size() >= 32 * (i + 1))
            for (int k = 0; k < 32; k++) w[31-k] = fall_q[32*i+k][0];
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        en      = 1'b0;
        fifo_wr = 1'b0;
        repeat (3) @(negedge clk);
        fall_q.delete();
        mq.delete();
        uf_cnt   = 0;
        uf_long  = 0;
        hold_l   = '0;
        hold_r   = '0;
        slot_idx = 0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_wr    = 1'b1;
        fifo_wdata = w;
        @(negedge clk);
        fifo_wr = 1'b0;
        if (mq.size() < 32) mq.push_back(w);
    endtask

    task automatic wait_falls(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (fall_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Enable, run nslots slots and compare each against the slot-level model.
    task automatic run_slots(input string name, input int nslots, input bit lvl_chk, input int pause_at);
        int          exp_uf;
        int          ch;
        int          n0;
        bit          enb, ok, ws_ok;
        logic [31:0] s, exp_w, obs_w;
        uf_cnt  = 0;
        uf_long = 0;
        exp_uf  = 0;
        en      = 1'b1;
        for (int i = 0; i < nslots; i++) begin
            ch  = slot_idx % 2;
            enb = (ch == 0) ? channels[1] : channels[0];
            if (!enb) begin
                s = '0;
            end else if (mq.size() > 0) begin
                s = mq.pop_front();
                if (ch == 0) hold_l = s; else hold_r = s;
            end else begin
                exp_uf++;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
                s = (ch == 0) ? hold_l : hold_r;
`else
                s = '0;
`endif
            end
            exp_w = slot_word(s, int'(sample_size), left_justified);
            wait_falls(32 * (slot_idx + 1), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s timeout in slot %0d: falls=%0d required=%0d",
                         name, slot_idx, fall_q.size(), 32 * (slot_idx + 1));
                en = 1'b0;
                return;
            end
            obs_w = obs_slot(slot_idx);
            ws_ok = 1'b1;
            for (int k = 0; k < 32; k++)
                if (fall_q[32*slot_idx+k][1] !== 1'(ch)) ws_ok = 1'b0;
            if (obs_w !== exp_w || !ws_ok) begin
                errors++;
                $display("FAIL %s slot %0d: sdo=%08h ws_ok=%0d, expected sdo=%08h ws=%0d",
                         name, slot_idx, obs_w, ws_ok, exp_w, ch);
            end
            if (lvl_chk && ch == 1) begin
                checks++;
                if (fifo_level !== 6'(mq.size())) begin
                    errors++;
                    $display("FAIL %s level after slot %0d: got %0d expected %0d",
                             name, slot_idx, fifo_level, mq.size());
                end
            end
            if (pause_at == i) begin
                en = 1'b0;
                n0 = fall_q.size();
                repeat (10 + $urandom_range(0, 10)) @(negedge clk);
                checks++;
                if (fall_q.size() != n0 || underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pause: falls=%0d expected %0d", name, fall_q.size(), n0);
                end
                en = 1'b1;
            end
            slot_idx++;
        end
        en = 1'b0;
        checks++;
        if (uf_cnt != exp_uf || uf_long != 0) begin
            errors++;
            $display("FAIL %s underflow: pulses=%0d long=%0d expected pulses=%0d long=0",
                     name, uf_cnt, uf_long, exp_uf);
        end
    endtask

    task automatic test_reset();
        fifo_level_threshold = 6'd4;
        do_reset();
        checks++;
        if ({sck, ws, sdo, underflow} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_io: sck/ws/sdo/uf=%b expected 0100", {sck, ws, sdo, underflow});
        end
        checks++;
        if ({fifo_empty, fifo_full} !== 2'b10 || fifo_level !== 6'd0 || fifo_level_below !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: empty=%b full=%b level=%0d below=%b expected 1 0 0 1",
                     fifo_empty, fifo_full, fifo_level, fifo_level_below);
        end
        channels       = 2'b11;
        sck_prescaler  = 8'd0;
        left_justified = 1'b0;
        sample_size    = 5'd8;
        for (int i = 0; i < 3; i++) push($urandom | 32'h1);
        en = 1'b1;
        repeat (40) @(negedge clk);
        do_reset();
        checks++;
        if (fifo_level !== 6'd0 || fifo_empty !== 1'b1 || ws !== 1'b1 || sck !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: level=%0d empty=%b ws=%b sck=%b expected 0 1 1 0",
                     fifo_level, fifo_empty, ws, sck);
        end
        run_slots("after_reset", 2, 1'b0, -1);
    endtask

    task automatic test_clocking();
        int   tog[4];
        int   wtog[3];
        int   nt, nw;
        logic psck, pws;
        do_reset();
        channels      = 2'b00;
        sck_prescaler = 8'd3;
        tog  = '{default: 0};
        wtog = '{default: 0};
        nt = 0; nw = 0;
        psck = sck; pws = ws;
        en = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (sck !== psck && nt < 4) begin tog[nt] = c; nt++; end
            if (ws !== pws && nw < 3) begin wtog[nw] = c; nw++; end
            psck = sck;
            pws  = ws;
        end
        en = 1'b0;
        checks++;
        if (nt != 4 || tog[0] != 1 || tog[1] != 5) begin
            errors++;
            $display("FAIL sck_first: toggles=%0d at %0d,%0d expected 4 at 1,5", nt, tog[0], tog[1]);
        end
        checks++;
        if (tog[2] - tog[0] != 8 || tog[3] - tog[1] != 8) begin
            errors++;
            $display("FAIL sck_period: %0d,%0d expected 8,8", tog[2] - tog[0], tog[3] - tog[1]);
        end
        checks++;
        if (nw != 3 || wtog[0] != tog[1]) begin
            errors++;
            $display("FAIL ws_first: ws toggles=%0d first at %0d expected 3 at %0d", nw, wtog[0], tog[1]);
        end
        checks++;
        if (wtog[1] - wtog[0] != 256 || wtog[2] - wtog[0] != 512) begin
            errors++;
            $display("FAIL ws_period: half=%0d full=%0d expected 256 512",
                     wtog[1] - wtog[0], wtog[2] - wtog[0]);
        end
    endtask

    task automatic test_philips();
        do_reset();
        left_justified = 1'b0;
        sample_size    = 5'd16;
        channels       = 2'b11;
        sck_prescaler  = 8'd0;
        push(32'h0000A5C3);
        push(32'h00001234);
        run_slots("philips", 2, 1'b0, -1);
        checks++;
        if (obs_slot(0) !== 32'h52E18000 || obs_slot(1) !== 32'h091A0000) begin
            errors++;
            $display("FAIL philips_words: left=%08h right=%08h expected 52e18000 091a0000",
                     obs_slot(0), obs_slot(1));
        end
    endtask

    task automatic test_left_just();
        do_reset();
        left_justified = 1'b1;
        sample_size    = 5'd24;
        channels       = 2'b10;
        sck_prescaler  = 8'd1;
        push(32'h00800001);
        run_slots("left_just", 2, 1'b0, -1);
        checks++;
        if (obs_slot(0) !== 32'h80000100 || obs_slot(1) !== 32'h0) begin
            errors++;
            $display("FAIL lj_words: left=%08h right=%08h expected 80000100 00000000",
                     obs_slot(0), obs_slot(1));
        end
    endtask

    task automatic test_left_only();
        do_reset();
        left_justified = 1'($urandom_range(0, 1));
        sample_size    = 5'($urandom_range(1, 31));
        channels       = 2'b10;
        sck_prescaler  = 8'd0;
        for (int i = 0; i < 5; i++) push($urandom);
        run_slots("left_only", 8, 1'b1, -1);
    endtask

    task automatic test_underflow();
        do_reset();
        left_justified = 1'b1;
        sample_size    = 5'd8;
        channels       = 2'b10;
        sck_prescaler  = 8'd0;
        push(32'h000000B7);
        run_slots("underflow", 4, 1'b1, -1);
    endtask

    task automatic test_full();
        do_reset();
        left_justified       = 1'b0;
        sample_size          = 5'd31;
        channels             = 2'b10;
        sck_prescaler        = 8'd0;
        fifo_level_threshold = 6'd32;
        for (int i = 0; i < 33; i++) push($urandom);
        checks++;
        if (fifo_full !== 1'b1 || fifo_level !== 6'd32 || fifo_level_below !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: full=%b level=%0d below=%b expected 1 32 0",
                     fifo_full, fifo_level, fifo_level_below);
        end
        run_slots("full_pop", 1, 1'b0, -1);
        checks++;
        if (fifo_full !== 1'b0 || fifo_level !== 6'd31 || fifo_level_below !== 1'b1) begin
            errors++;
            $display("FAIL after_pop: full=%b level=%0d below=%b expected 0 31 1",
                     fifo_full, fifo_level, fifo_level_below);
        end
        channels = 2'b11;
        run_slots("full_drain", 33, 1'b0, -1);
        checks++;
        if (fifo_empty !== 1'b1 || fifo_level !== 6'd0) begin
            errors++;
            $display("FAIL drained: empty=%b level=%0d expected 1 0", fifo_empty, fifo_level);
        end
    endtask

    task automatic test_push_pop_collide();
        do_reset();
        left_justified = 1'b0;
        sample_size    = 5'd16;
        channels       = 2'b10;
        sck_prescaler  = 8'd0;
        push(32'h0000BEEF);
        uf_cnt  = 0;
        uf_long = 0;
        en = 1'b1;
        // Slot 2 starts at the 130th enabled edge and slot 4 at the 258th.
        repeat (129) @(negedge clk);
        fifo_wr = 1'b1; fifo_wdata = 32'h00001111;
        @(negedge clk);
        fifo_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 6'd1 || fifo_empty !== 1'b0 || uf_cnt != 1 || uf_long != 0) begin
            errors++;
            $display("FAIL push_pop_empty: level=%0d empty=%b uf=%0d long=%0d expected 1 0 1 0",
                     fifo_level, fifo_empty, uf_cnt, uf_long);
        end
        repeat (126) @(negedge clk);
        fifo_wr = 1'b1; fifo_wdata = 32'h00002222;
        @(negedge clk);
        fifo_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 6'd1 || uf_cnt != 1) begin
            errors++;
            $display("FAIL push_pop_busy: level=%0d uf=%0d expected 1 1", fifo_level, uf_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            left_justified = 1'($urandom_range(0, 1));
            sample_size    = 5'($urandom_range(1, 31));
            channels       = 2'($urandom_range(0, 3));
            sck_prescaler  = 8'($urandom_range(0, 2));
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) push($urandom);
            run_slots("random", 8, 1'b1, int'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        en                   = 1'b0;
        fifo_wr              = 1'b0;
        fifo_wdata           = '0;
        fifo_level_threshold = 6'd0;
        left_justified       = 1'b0;
        sample_size          = 5'd16;
        sck_prescaler        = 8'd0;
        channels             = 2'b11;
        test_reset();
        test_clocking();
        test_philips();
        test_left_just();
        test_left_only();
        test_underflow();
        test_full();
        test_push_pop_collide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_AW, default 5: log2 of the transmit FIFO depth (32 words).
REQ-002 SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
REQ-003 SHALL have the I2S output ports:
- sck  out  1  serial clock
- ws  out  1  word select: 0 = left, 1 = right
- sdo  out  1  serial data
REQ-004 SHALL have the FIFO ports:
- fifo_wr  in  1  push strobe
- fifo_wdata  in  32  sample, right-aligned
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty
- fifo_level  out  FIFO_AW+1  word count
- fifo_level_threshold  in  FIFO_AW+1  refill threshold
- fifo_level_below  out  1  fifo_level < fifo_level_threshold
REQ-005 SHALL have the control and status ports:
- left_justified  in  1  1 = left-justified, 0 = Philips
- sample_size  in  5  bits per sample, valid 1..31
- sck_prescaler  in  8  sck half-period minus 1, in clk cycles
- channels  in  2  bit1 = left enabled, bit0 = right enabled
- en  in  1  enable
- underflow  out  1  one-cycle pulse

Function
REQ-006 SHALL, while en=1, count prescaler down to 0 and then reload it from sck_prescaler, toggling sck on each cycle where prescaler==0; sck half-period = sck_prescaler+1 clk cycles.
REQ-007 SHALL, while en=0, freeze prescaler, sck, ws, sdo and the bit counter, and resume from the same state when en returns to 1.
REQ-008 SHALL treat each sck 1->0 toggle as a falling event; every output change other than FIFO flags happens only on falling events.
REQ-009 SHALL increment a 5-bit bit counter k on each falling event; when k==31 it wraps to 0, ws toggles, and a new 32-bit slot starts.
REQ-010 SHALL, at slot start, pop one FIFO word into the slot sample register if the slot's channel is enabled in channels (ws new value 0 → channels[1]; 1 → channels[0]); a disabled slot loads 0 and does not pop.
REQ-011 SHALL drive sdo in slot bit k, with N = sample_size and S = slot sample, as follows:
- left_justified=1: S[N-1-k] for k<N, else 0.
- Philips: 0 at k=0, S[N-k] for 1<=k<=N, else 0.
REQ-012 SHALL, when a pop is required and fifo_empty=1, pulse underflow for one clk cycle, leave the FIFO unchanged, and load the underflow value per REQ-019.
REQ-013 SHALL ignore a push while fifo_full=1, including a push in the same cycle as a pop.
REQ-014 SHALL, on simultaneous push and pop with the FIFO neither full nor empty, accept both and leave fifo_level unchanged.
REQ-015 SHALL, on simultaneous push and pop with the FIFO empty, accept the push, flag underflow, and end with fifo_level=1.
REQ-016 SHALL update fifo_full, fifo_empty and fifo_level registered, one cycle after the push or pop, with fifo_level in the range 0..2^FIFO_AW; fifo_level_below is combinational from fifo_level.

Reset
REQ-017 SHALL reset outputs to: sck=0, ws=1, sdo=0, underflow=0, fifo_empty=1, fifo_full=0, fifo_level=0.
REQ-018 SHALL reset prescaler to 0, bit counter to 31 and slot sample to 0, so the first falling event starts a left slot; a reset mid-frame discards all FIFO contents.

Configuration
REQ-019 SHALL use macro I2S_TX_UNDERFLOW_HOLD_EN: defined → an underflow slot repeats the last sample loaded for that channel; undefined → an underflow slot transmits all zeros.

Structure
REQ-020 SHALL place the ws channel encoding (LEFT=0, RIGHT=1) and the default FIFO_AW in shared package i2s_pkg.
REQ-021 SHALL implement the FIFO as sub-module i2s_tx_fifo (registered pointers, full/empty/level flags, combinational read data).

Verification
REQ-022 SHALL cover: sck_prescaler=3, en=1 → sck period of 8 clk; ws period of 64 sck; first ws falls on the second sck toggle after en rises.
REQ-023 SHALL cover: Philips mode, sample_size=16, push 0x0000A5C3 then 0x00001234, channels=11 → left slot sdo = 0,1010010111000011, then zeros; right slot carries 0x1234, one sck delayed.
REQ-024 SHALL cover: left_justified=1, sample_size=24, push 0x00800001 → MSB 1 at k=0, 1 at k=23, 0 elsewhere.
REQ-025 SHALL cover: channels=10 → only left slots pop; right slots are all zeros; fifo_level decrements once per frame.
REQ-026 SHALL cover: empty FIFO at slot start → underflow pulse of exactly 1 clk; slot is zeros (macro undefined) or repeats the previous left sample (macro defined).
REQ-027 SHALL cover: push 33 words with no pop → fifo_full=1 and fifo_level=32; the 33rd word is dropped; after the first pop, fifo_full=0 and fifo_level_below=1 with fifo_level_threshold=32.
